cex_enum_search: RTL and testbench

Sequential exhaustive-enumeration engine that sits directly upstream of the team's AIG-dumped combinational predicate modules. It drives one candidate input assignment per clock onto the predicate's primary inputs and samples the predicate's single output in the same cycle. Every satisfying assignment (a counterexample/witness) is queued in a small FIFO and streamed out over a valid/ready interface. It is the search front end for knowledge-compilation counterexample checks on predicates of up to 16 inputs.

---
 rtl/cex_kc_pkg.sv | 22 ++
 rtl/cex_wit_fifo.sv | 56 +++++
 rtl/cex_enum_search.sv | 118 +++++++++++
 tb/tb_cex_enum_search.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cex_kc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cex_kc_pkg : shared types and helpers for the counterexample search engine
// Revision   : 1.0
// ---------------------------------------------------------------------------
package cex_kc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cex_enum_state_t;

  localparam int c_NIN_DEFAULT = 16;

  function automatic int cex_ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cex_wit_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cex_wit_fifo : witness FIFO, power-of-two depth, head read from storage flops
// Revision     : 1.0
// ---------------------------------------------------------------------------
module cex_wit_fifo
  import cex_kc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int c_PTR_W = cex_ptr_w(DEPTH);
  localparam int c_CW    = c_PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q;
  logic [c_PTR_W-1:0] rd_ptr_q;
  logic [c_CW-1:0]    count_q;
  logic               w_wr;
  logic               w_rd;

  assign full_o  = (count_q == c_CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  // A write into a full FIFO is legal only alongside a read.
  assign w_rd    = pop_i & ~empty_o;
  assign w_wr    = push_i & (~full_o | w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w_wr) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + c_PTR_W'(1);
      end
      if (w_rd) rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      if (w_wr && !w_rd)      count_q <= count_q + c_CW'(1);
      else if (!w_wr && w_rd) count_q <= count_q - c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cex_enum_search.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cex_enum_search : exhaustive predicate sweep, witnesses streamed via FIFO.
// Optional hit counter port enabled by CEX_ENUM_HITCOUNT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module cex_enum_search
  import cex_kc_pkg::*;
#(
  parameter int NIN           = c_NIN_DEFAULT,
  parameter int FIFO_DEPTH    = 4,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [NIN-1:0] vec_o,
  input  logic           sat_i,
  output logic           wit_valid,
  input  logic           wit_ready,
  output logic [NIN-1:0] wit_data,
  output logic           overflow
`ifdef CEX_ENUM_HITCOUNT_EN
  ,
  output logic [NIN:0]   hit_count
`endif
);
  localparam logic [NIN-1:0] c_CNT_LAST = '1;

  cex_enum_state_t state_q;
  logic [NIN-1:0]  cnt_q;
  logic            overflow_q;
  logic            w_sweep;
  logic            w_pop;
  logic            w_push;
  logic            w_stall;
  logic            w_full;
  logic            w_empty;

  assign w_sweep = (state_q == ST_SWEEP);
  assign w_pop   = wit_valid & wit_ready;
  // wit_ready feeds the stall path so a full FIFO can still take a push on a pop cycle.
  assign w_push  = w_sweep & sat_i & (~w_full | w_pop);
  assign w_stall = w_sweep & sat_i & w_full & ~w_pop;

  assign busy      = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign vec_o     = cnt_q;
  assign overflow  = overflow_q;
  assign wit_valid = ~w_empty;

  cex_wit_fifo #(
    .WIDTH (NIN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (cnt_q),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_o  (wit_data)
  );

`ifdef CEX_ENUM_HITCOUNT_EN
  localparam logic [NIN:0] c_HIT_MAX = {1'b1, {NIN{1'b0}}};
  logic [NIN:0] hit_q;
  assign hit_count = hit_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
`ifdef CEX_ENUM_HITCOUNT_EN
      hit_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          // The counter stays on the final vector when leaving so vec_o holds in DRAIN.
          if (w_stall) begin
            overflow_q <= 1'b1;
          end else if ((cnt_q == c_CNT_LAST) || ((STOP_ON_FIRST != 0) && w_push)) begin
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + NIN'(1);
          end
        end
        ST_DRAIN: begin
          if (w_empty) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
`ifdef CEX_ENUM_HITCOUNT_EN
      if ((state_q == ST_IDLE) && start) hit_q <= '0;
      else if (w_push && (hit_q != c_HIT_MAX)) hit_q <= hit_q + (NIN+1)'(1);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cex_enum_search.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cex_enum_search : randomized bench with a table-driven predicate and a
// list-based witness model. Honours CEX_ENUM_HITCOUNT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_cex_enum_search;
  localparam int NIN = 8;
  localparam int N   = 1 << NIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, ready_a, ready_b, sat_a, sat_b;
  logic busy_a, done_a, valid_a, ov_a, busy_b, done_b, valid_b, ov_b;
  logic [NIN-1:0] vec_a, data_a, vec_b, data_b;
`ifdef CEX_ENUM_HITCOUNT_EN
  logic [NIN:0] hc_a, hc_b;
`endif

  bit tab_a [N];
  bit tab_b [N];
  assign sat_a = tab_a[vec_a];
  assign sat_b = tab_b[vec_b];

  cex_enum_search #(.NIN(NIN), .FIFO_DEPTH(4), .STOP_ON_FIRST(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .vec_o(vec_a), .sat_i(sat_a), .wit_valid(valid_a), .wit_ready(ready_a),
    .wit_data(data_a), .overflow(ov_a)
`ifdef CEX_ENUM_HITCOUNT_EN
    , .hit_count(hc_a)
`endif
  );

  cex_enum_search #(.NIN(NIN), .FIFO_DEPTH(4), .STOP_ON_FIRST(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .vec_o(vec_b), .sat_i(sat_b), .wit_valid(valid_b), .wit_ready(ready_b),
    .wit_data(data_b), .overflow(ov_b)
`ifdef CEX_ENUM_HITCOUNT_EN
    , .hit_count(hc_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int n_done = 0;
  bit sel_b = 1'b0;
  logic [NIN-1:0] got_q [$];
  logic [NIN-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive ready, record handshakes/done for the cycle, advance.
  task automatic step(input bit rdy);
    logic v, d;
    logic [NIN-1:0] dat;
    if (sel_b) begin ready_b = rdy; v = valid_b; d = done_b; dat = data_b; end
    else       begin ready_a = rdy; v = valid_a; d = done_a; dat = data_a; end
    if (v === 1'b1 && rdy) got_q.push_back(dat);
    if (d === 1'b1) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic pulse_start(input string tag);
    got_q.delete();
    n_done   = 0;
    done_cyc = -1;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    step(1'b1);
    start_a = 1'b0;
    start_b = 1'b0;
    start_cyc = cyc;
    check({tag, "_busy_at_start"}, sel_b ? busy_b : busy_a, 1);
    check({tag, "_vec_at_start"},  sel_b ? vec_b : vec_a, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready once hold cycles elapsed
  task automatic run(input int mode, input int hold, input int restart_at, input string tag);
    bit rdy;
    for (int i = 0; i < 8 * N && done_cyc < 0; i++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = ((cyc - start_cyc) >= hold);
      endcase
      if (restart_at >= 0 && (cyc - start_cyc) == restart_at) begin
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      end
      step(rdy);
      start_a = 1'b0;
      start_b = 1'b0;
    end
    if (done_cyc < 0) check({tag, "_timeout"}, 0, 1);
    repeat (4) step(1'b1);
  endtask

  task automatic build_exp(input bit stop);
    exp_q.delete();
    for (int i = 0; i < N; i++)
      if ((sel_b ? tab_b[i] : tab_a[i]) && !(stop && exp_q.size() > 0))
        exp_q.push_back(NIN'(i));
  endtask

  task automatic compare(input string tag);
    check({tag, "_wit_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_wit"}, got_q[i], exp_q[i]);
    check({tag, "_done_once"}, n_done, 1);
    check({tag, "_idle_after"}, sel_b ? busy_b : busy_a, 0);
`ifdef CEX_ENUM_HITCOUNT_EN
    check({tag, "_hit_count"}, sel_b ? hc_b : hc_a, exp_q.size());
`endif
  endtask

  task automatic fill_random_a(input int one_in);
    for (int i = 0; i < N; i++) tab_a[i] = ($urandom_range(0, one_in - 1) == 0);
  endtask

  initial begin
    int w;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < N; i++) begin tab_a[i] = 1'b0; tab_b[i] = 1'b0; end
    @(posedge clk); #1;
    repeat (3) step(1'b0);
    rst = 1'b0;
    step(1'b0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_vec", vec_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_overflow", ov_a, 0);
`ifdef CEX_ENUM_HITCOUNT_EN
    check("rst_hit_count", hc_a, 0);
`endif

    // Single witness, always ready: exact completion time.
    w = $urandom_range(1, N - 2);
    tab_a[w] = 1'b1;
    build_exp(1'b0);
    pulse_start("single");
    run(0, 0, -1, "single");
    compare("single");
    check("single_done_cyc", done_cyc - start_cyc, N + 1);
    check("single_overflow", ov_a, 0);

    // Random sparse predicates, always ready; a hit on the last vector costs one drain cycle.
    for (int r = 0; r < 3; r++) begin
      fill_random_a(r + 3);
      if (r == 2) tab_a[N-1] = 1'b1;
      build_exp(1'b0);
      pulse_start("rand_rdy");
      run(0, 0, -1, "rand_rdy");
      compare("rand_rdy");
      check("rand_rdy_done_cyc", done_cyc - start_cyc, N + 1 + int'(tab_a[N-1]));
      check("rand_rdy_overflow", ov_a, 0);
    end

    // Random predicate with random backpressure: order and completeness only.
    fill_random_a(2);
    build_exp(1'b0);
    pulse_start("rand_bp");
    run(1, 0, -1, "rand_bp");
    compare("rand_bp");

    // Stall: hits 0..7, consumer blocked for 20 cycles.
    for (int i = 0; i < N; i++) tab_a[i] = (i < 8);
    build_exp(1'b0);
    pulse_start("stall");
    repeat (10) step(1'b0);
    check("stall_vec_held", vec_a, 4);
    check("stall_overflow", ov_a, 1);
    check("stall_valid", valid_a, 1);
    check("stall_data_stable", data_a, 0);
    run(2, 20, -1, "stall");
    compare("stall");
    check("stall_overflow_sticky", ov_a, 1);

    // No witness, start re-pulsed mid-sweep.
    for (int i = 0; i < N; i++) tab_a[i] = 1'b0;
    build_exp(1'b0);
    pulse_start("nowit");
    check("nowit_overflow_cleared", ov_a, 0);
    run(0, 0, 50, "nowit");
    compare("nowit");
    check("nowit_done_cyc", done_cyc - start_cyc, N + 1);

    // Every vector satisfies; the table stays set after done to show sat_i is ignored in IDLE.
    for (int i = 0; i < N; i++) tab_a[i] = 1'b1;
    build_exp(1'b0);
    pulse_start("allsat");
    run(0, 0, -1, "allsat");
    compare("allsat");
    check("allsat_done_cyc", done_cyc - start_cyc, N + 2);
    check("allsat_overflow", ov_a, 0);

    // Reset mid-sweep with a stalled, non-empty FIFO, then a clean restart.
    pulse_start("midrst");
    repeat (99) step(1'b0);
    check("midrst_pre_overflow", ov_a, 1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("midrst_busy", busy_a, 0);
    check("midrst_vec", vec_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_overflow", ov_a, 0);
    check("midrst_data", data_a, 0);
    fill_random_a(5);
    build_exp(1'b0);
    pulse_start("restart");
    run(0, 0, -1, "restart");
    compare("restart");

    // Stop on first: predicate true from a random threshold upward.
    sel_b = 1'b1;
    w = $urandom_range(1, N - 8);
    for (int i = 0; i < N; i++) tab_b[i] = (i >= w);
    build_exp(1'b1);
    pulse_start("stopfirst");
    run(0, 0, -1, "stopfirst");
    compare("stopfirst");
    check("stopfirst_done_window",
          ((done_cyc - (start_cyc + w)) >= 1) && ((done_cyc - (start_cyc + w)) <= 4), 1);
    check("stopfirst_overflow", ov_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
